// File: rtl/butterfly_weight_pkg.sv
// Shared FSM state type, beat width and length helpers for the butterfly weight path.
package butterfly_weight_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

   localparam int DEF_DATA_WIDTH     = 16;
   localparam int DEF_BU_PARALLELISM = 4;
   localparam int BEAT_WIDTH         = DEF_DATA_WIDTH * 4 * DEF_BU_PARALLELISM;

   // Index of the highest set bit; exact log2 when len is a power of two.
   function automatic logic [4:0] log2_pow2(input logic [15:0] len);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         if (len[i]) r = 5'(i);
      return r;
   endfunction

   function automatic logic len_legal(input logic [15:0] len,
                                      input logic [16:0] min_len,
                                      input logic [16:0] max_len);
      logic pow2;
      pow2 = (len != 16'd0) && ((len & (len - 16'd1)) == 16'd0);
      return pow2 && ({1'b0, len} >= min_len) && ({1'b0, len} <= max_len);
   endfunction

endpackage

// File: rtl/butterfly_len_decode.sv
// Combinational transform-length decode: legality, beats per stage and stage count.
module butterfly_len_decode
   import butterfly_weight_pkg::*;
#(
   parameter int BU_PARALLELISM = 4,
   parameter int MAX_LENGTH     = 1024
) (
   input  logic [15:0] length,
   output logic        legal,
   output logic [15:0] depth,
   output logic [4:0]  stages
);

   localparam logic [4:0] BEAT_SHIFT = log2_pow2(16'(2 * BU_PARALLELISM));

   always_comb begin
      legal  = len_legal(length, 17'(2 * BU_PARALLELISM), 17'(MAX_LENGTH));
      depth  = length >> BEAT_SHIFT;
      stages = log2_pow2(length);
   end

endmodule

// File: rtl/butterfly_weight_streamer.sv
// Streams every stage's twiddle words from the weight SRAM to the butterfly weight port.
// Define BUTTERFLY_WEIGHT_PACE_EN to issue one read every other cycle.
module butterfly_weight_streamer
   import butterfly_weight_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int BU_PARALLELISM = DEF_BU_PARALLELISM,
   parameter int ADDR_WIDTH     = 12,
   parameter int MAX_LENGTH     = 1024
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   input  logic                                   abort,
   input  logic [15:0]                            length,
   input  logic [ADDR_WIDTH-1:0]                  base_addr,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   err,
   output logic                                   mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                  mem_rd_addr,
   input  logic [DATA_WIDTH*4*BU_PARALLELISM-1:0] mem_rd_dat,
   output logic                                   up_weight_vld,
   output logic [DATA_WIDTH*4*BU_PARALLELISM-1:0] up_weight_dat,
   output logic [3:0]                             up_weight_stage,
   output logic                                   up_weight_stage_last
);

   localparam int BEAT_W = DATA_WIDTH * 4 * BU_PARALLELISM;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   state_t state_q, state_nxt;

   logic        dec_legal;
   logic [15:0] dec_depth;
   logic [4:0]  dec_stages;

   logic [15:0] depth_q, idx_q;
   logic [4:0]  stages_q, stage_q;
   logic        err_q;

   logic        issue, first, flush, bad_start, pace_skip;
   logic [15:0] iss_depth, iss_idx;
   logic [4:0]  iss_stages, iss_stage;
   logic        iss_last, iss_end;

   logic                  rd_en_p0;
   logic [ADDR_WIDTH-1:0] rd_addr_p0;
   logic [3:0]            stage_p0;
   logic                  last_p0, end_p0;

   logic                  vld_p1;
   logic [3:0]            stage_p1;
   logic                  last_p1, end_p1;

   logic                  vld_p2;
   logic [BEAT_W-1:0]     dat_p2;
   logic [3:0]            stage_p2;
   logic                  last_p2, end_p2;

   butterfly_len_decode #(
      .BU_PARALLELISM (BU_PARALLELISM),
      .MAX_LENGTH     (MAX_LENGTH)
   ) u_len_decode (
      .length (length),
      .legal  (dec_legal),
      .depth  (dec_depth),
      .stages (dec_stages)
   );

`ifdef BUTTERFLY_WEIGHT_PACE_EN
   logic phase_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  phase_q <= 1'b0;
      else if (flush)              phase_q <= 1'b0;
      else if (issue)              phase_q <= 1'b1;
      else if (state_q == ST_READ) phase_q <= 1'b0;
   end

   assign pace_skip = phase_q;
`else
   assign pace_skip = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      issue     = 1'b0;
      first     = 1'b0;
      flush     = 1'b0;
      bad_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               if (dec_legal) begin
                  state_nxt = ST_READ;
                  issue     = 1'b1;
                  first     = 1'b1;
               end else begin
                  bad_start = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (abort) begin
               flush     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (stage_q == stages_q) begin
               state_nxt = ST_DRAIN;
            end else if (!pace_skip) begin
               issue = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               flush     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (vld_p2 && end_p2) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // The first beat is issued from the decoder directly, before depth/stages are latched.
   always_comb begin
      iss_depth  = first ? dec_depth  : depth_q;
      iss_stages = first ? dec_stages : stages_q;
      iss_stage  = first ? 5'd0       : stage_q;
      iss_idx    = first ? 16'd0      : idx_q;
      iss_last   = (iss_idx == iss_depth - 16'd1);
      iss_end    = iss_last && (iss_stage == iss_stages - 5'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_q  <= '0;
         stages_q <= '0;
         stage_q  <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= bad_start;
         if (first) begin
            depth_q  <= dec_depth;
            stages_q <= dec_stages;
         end
         if (issue) begin
            if (iss_last) begin
               idx_q   <= '0;
               stage_q <= iss_stage + 5'd1;
            end else begin
               idx_q   <= iss_idx + 16'd1;
               stage_q <= iss_stage;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_p0   <= 1'b0;
         rd_addr_p0 <= '0;
         stage_p0   <= '0;
         last_p0    <= 1'b0;
         end_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         stage_p1   <= '0;
         last_p1    <= 1'b0;
         end_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         dat_p2     <= '0;
         stage_p2   <= '0;
         last_p2    <= 1'b0;
         end_p2     <= 1'b0;
      end else begin
         // p0: registered SRAM read request
         rd_en_p0 <= issue;
         if (issue) begin
            rd_addr_p0 <= first ? base_addr : rd_addr_p0 + ADDR_ONE;
            stage_p0   <= iss_stage[3:0];
            last_p0    <= iss_last;
            end_p0     <= iss_end;
         end
         // p1: SRAM word present on mem_rd_dat
         vld_p1   <= rd_en_p0 && !flush;
         stage_p1 <= stage_p0;
         last_p1  <= last_p0;
         end_p1   <= end_p0;
         // p2: captured weight beat
         vld_p2 <= vld_p1 && !flush;
         if (vld_p1 && !flush) begin
            dat_p2   <= mem_rd_dat;
            stage_p2 <= stage_p1;
            last_p2  <= last_p1;
            end_p2   <= end_p1;
         end else begin
            last_p2 <= 1'b0;
            end_p2  <= 1'b0;
         end
      end
   end

   assign busy                 = (state_q != ST_IDLE);
   assign done                 = (state_q == ST_DONE);
   assign err                  = err_q;
   assign mem_rd_en            = rd_en_p0;
   assign mem_rd_addr          = rd_addr_p0;
   assign up_weight_vld        = vld_p2;
   assign up_weight_dat        = dat_p2;
   assign up_weight_stage      = stage_p2;
   assign up_weight_stage_last = last_p2;

endmodule

// File: tb/tb_butterfly_weight_streamer.sv
// Directed bench for butterfly_weight_streamer with a cycle-level stream model and SRAM model.
module tb_butterfly_weight_streamer;
   import butterfly_weight_pkg::*;

`ifdef BUTTERFLY_WEIGHT_PACE_EN
   localparam bit PACE = 1'b1;
`else
   localparam bit PACE = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic [15:0]           length = '0;
   logic [11:0]           base_addr = '0;
   logic                  busy, done, err, mem_rd_en;
   logic [11:0]           mem_rd_addr;
   logic [BEAT_WIDTH-1:0] mem_rd_dat = '0;
   logic                  up_weight_vld;
   logic [BEAT_WIDTH-1:0] up_weight_dat;
   logic [3:0]            up_weight_stage;
   logic                  up_weight_stage_last;

   int total_n = 0;
   int bad_n   = 0;
   int cyc     = 0;

   // stream model: kind 0 = nothing, 1 = legal stream, 2 = rejected start
   int m_kind = 0, m_c0 = 0, m_B = 0, m_depth = 1, m_T = 0, m_done_rel = 0;
   int m_ra = 1 << 30;
   logic [BEAT_WIDTH-1:0] exp_hold = '0;

   int obs_beats = 0, obs_lasts = 0, obs_first_vld = -1, obs_done_rel = -1;
   int obs_last_stage = -1, obs_err_cnt = 0, obs_busy_cnt = 0;
   int obs_rd_cnt = 0, obs_rd_first = -1, obs_rd_last = -1;

   butterfly_weight_streamer dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start                (start),
      .abort                (abort),
      .length               (length),
      .base_addr            (base_addr),
      .busy                 (busy),
      .done                 (done),
      .err                  (err),
      .mem_rd_en            (mem_rd_en),
      .mem_rd_addr          (mem_rd_addr),
      .mem_rd_dat           (mem_rd_dat),
      .up_weight_vld        (up_weight_vld),
      .up_weight_dat        (up_weight_dat),
      .up_weight_stage      (up_weight_stage),
      .up_weight_stage_last (up_weight_stage_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [BEAT_WIDTH-1:0] sram_word(input int a);
      logic [BEAT_WIDTH-1:0] w;
      for (int k = 0; k < BEAT_WIDTH / 16; k++)
         w[16*k +: 16] = 16'(a * 31 + k * 257 + 'h1234);
      return w;
   endfunction

   // SRAM with one-cycle read latency; garbage when not read.
   always @(posedge clk)
      mem_rd_dat <= mem_rd_en ? sram_word(int'(mem_rd_addr)) : {(BEAT_WIDTH/16){16'hDEAD}};

   function automatic bit is_legal(input int L);
      int n;
      n = 0;
      for (int i = 0; i < 17; i++)
         if ((L >> i) & 1) n++;
      return (n == 1) && (L >= 8) && (L <= 1024);
   endfunction

   function automatic int ilog2(input int L);
      int r;
      r = 0;
      while ((1 << (r + 1)) <= L) r++;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [BEAT_WIDTH-1:0] act,
                      input logic [BEAT_WIDTH-1:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int rel, j;
      logic e_vld, e_rd, e_busy, e_done, e_err, e_last;
      logic [3:0]  e_stage;
      logic [11:0] e_addr;
      rel = cyc - m_c0;
      e_vld = 1'b0; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_last = 1'b0;
      e_stage = '0; e_addr = '0; j = 0;
      if (rel == 0) begin
         obs_beats = 0; obs_lasts = 0; obs_first_vld = -1; obs_done_rel = -1;
         obs_last_stage = -1; obs_err_cnt = 0; obs_busy_cnt = 0;
         obs_rd_cnt = 0; obs_rd_first = -1; obs_rd_last = -1;
      end
      if (!rst_n) begin
         exp_hold = '0;
      end else if (m_kind == 2) begin
         e_err = (rel == 1);
      end else if (m_kind == 1 && rel <= m_ra) begin
         e_busy = (rel >= 1) && (rel <= m_done_rel);
         e_done = (rel == m_done_rel);
         if (PACE) begin
            if (rel >= 1 && rel <= 2*m_T - 1 && rel % 2 == 1) begin
               e_rd = 1'b1; e_addr = 12'((m_B + (rel - 1) / 2) % 4096);
            end
            if (rel >= 3 && rel <= 2*m_T + 1 && rel % 2 == 1) begin
               e_vld = 1'b1; j = (rel - 3) / 2;
            end
         end else begin
            if (rel >= 1 && rel <= m_T) begin
               e_rd = 1'b1; e_addr = 12'((m_B + rel - 1) % 4096);
            end
            if (rel >= 3 && rel <= m_T + 2) begin
               e_vld = 1'b1; j = rel - 3;
            end
         end
         if (e_vld) begin
            e_stage  = 4'(j / m_depth);
            e_last   = ((j % m_depth) == m_depth - 1);
            exp_hold = sram_word((m_B + j) % 4096);
         end
      end
      chk("vld", BEAT_WIDTH'(up_weight_vld), BEAT_WIDTH'(e_vld));
      chk("busy", BEAT_WIDTH'(busy), BEAT_WIDTH'(e_busy));
      chk("done", BEAT_WIDTH'(done), BEAT_WIDTH'(e_done));
      chk("err", BEAT_WIDTH'(err), BEAT_WIDTH'(e_err));
      chk("rd_en", BEAT_WIDTH'(mem_rd_en), BEAT_WIDTH'(e_rd));
      chk("dat", up_weight_dat, exp_hold);
      if (e_rd) chk("rd_addr", BEAT_WIDTH'(mem_rd_addr), BEAT_WIDTH'(e_addr));
      if (e_vld) begin
         chk("stage", BEAT_WIDTH'(up_weight_stage), BEAT_WIDTH'(e_stage));
         chk("stage_last", BEAT_WIDTH'(up_weight_stage_last), BEAT_WIDTH'(e_last));
      end
      if (!rst_n) begin
         chk("rst_addr", BEAT_WIDTH'(mem_rd_addr), '0);
         chk("rst_stage", BEAT_WIDTH'(up_weight_stage), '0);
      end
      if (up_weight_vld) begin
         if (obs_beats == 0) obs_first_vld = rel;
         obs_beats++;
         if (up_weight_stage_last) obs_lasts++;
         obs_last_stage = int'(up_weight_stage);
      end
      if (done) obs_done_rel = rel;
      if (err) obs_err_cnt++;
      if (busy) obs_busy_cnt++;
      if (mem_rd_en) begin
         if (obs_rd_cnt == 0) obs_rd_first = int'(mem_rd_addr);
         obs_rd_last = int'(mem_rd_addr);
         obs_rd_cnt++;
      end
   end

   task automatic launch(input int L, input int B, input bit with_abort);
      @(posedge clk); #1;
      length    = 16'(L);
      base_addr = 12'(B);
      start     = 1'b1;
      abort     = with_abort;
      m_c0      = cyc;
      m_B       = B;
      m_ra      = with_abort ? 0 : (1 << 30);
      if (is_legal(L)) begin
         m_kind     = 1;
         m_depth    = L / 8;
         m_T        = m_depth * ilog2(L);
         m_done_rel = PACE ? 2*m_T + 2 : m_T + 3;
      end else begin
         m_kind = with_abort ? 0 : 2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic goto_rel(input int r);
      while (cyc - m_c0 < r) begin
         @(posedge clk); #1;
      end
   endtask

   localparam int EXP_DONE_1024 = PACE ? 2562 : 1283;
   localparam int EXP_DONE_8    = PACE ? 8 : 6;
   localparam int EXP_DONE_16   = PACE ? 18 : 11;
   localparam int EXP_DONE_64   = PACE ? 98 : 51;
   localparam int ABORT_REL     = PACE ? 203 : 103;
   localparam int ABORT_RD      = PACE ? 102 : 103;
   localparam int SECOND_REL    = PACE ? 23 : 13;

   initial begin
      int bad_len [3];
      bad_len[0] = 1000; bad_len[1] = 4096; bad_len[2] = 4;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", BEAT_WIDTH'(busy), '0);
      chk("reset_vld", BEAT_WIDTH'(up_weight_vld), '0);
      chk("reset_rd_en", BEAT_WIDTH'(mem_rd_en), '0);
      chk("reset_dat", up_weight_dat, '0);
      rst_n = 1'b1;

      // full 1024-point stream with an ignored start mid-stream
      launch(1024, 0, 1'b0);
      goto_rel(SECOND_REL);
      start = 1'b1; length = 16'd16;
      @(posedge clk); #1;
      start = 1'b0;
      goto_rel(EXP_DONE_1024 + 3);
      chk("l1024_done_cycle", BEAT_WIDTH'(obs_done_rel), BEAT_WIDTH'(EXP_DONE_1024));
      chk("l1024_first_vld", BEAT_WIDTH'(obs_first_vld), BEAT_WIDTH'(3));
      chk("l1024_beats", BEAT_WIDTH'(obs_beats), BEAT_WIDTH'(1280));
      chk("l1024_lasts", BEAT_WIDTH'(obs_lasts), BEAT_WIDTH'(10));
      chk("l1024_last_stage", BEAT_WIDTH'(obs_last_stage), BEAT_WIDTH'(9));
      chk("l1024_rd_last", BEAT_WIDTH'(obs_rd_last), BEAT_WIDTH'(1279));

      launch(8, 5, 1'b0);
      goto_rel(EXP_DONE_8 + 3);
      chk("l8_done_cycle", BEAT_WIDTH'(obs_done_rel), BEAT_WIDTH'(EXP_DONE_8));
      chk("l8_beats", BEAT_WIDTH'(obs_beats), BEAT_WIDTH'(3));
      chk("l8_lasts", BEAT_WIDTH'(obs_lasts), BEAT_WIDTH'(3));
      chk("l8_last_stage", BEAT_WIDTH'(obs_last_stage), BEAT_WIDTH'(2));
      chk("l8_rd_first", BEAT_WIDTH'(obs_rd_first), BEAT_WIDTH'(5));

      for (int i = 0; i < 3; i++) begin
         launch(bad_len[i], 0, 1'b0);
         goto_rel(5);
         chk("illegal_err_cnt", BEAT_WIDTH'(obs_err_cnt), BEAT_WIDTH'(1));
         chk("illegal_rd_cnt", BEAT_WIDTH'(obs_rd_cnt), '0);
         chk("illegal_busy_cnt", BEAT_WIDTH'(obs_busy_cnt), '0);
      end

      // abort while beat 100 is on the port
      launch(1024, 0, 1'b0);
      goto_rel(ABORT_REL);
      abort = 1'b1;
      m_ra  = ABORT_REL;
      @(posedge clk); #1;
      abort = 1'b0;
      goto_rel(ABORT_REL + 6);
      chk("abort_no_done", BEAT_WIDTH'(obs_done_rel), BEAT_WIDTH'(-1));
      chk("abort_beats", BEAT_WIDTH'(obs_beats), BEAT_WIDTH'(101));
      chk("abort_rd_cnt", BEAT_WIDTH'(obs_rd_cnt), BEAT_WIDTH'(ABORT_RD));

      launch(16, 100, 1'b1);
      goto_rel(6);
      chk("abort_start_beats", BEAT_WIDTH'(obs_beats), '0);
      chk("abort_start_busy", BEAT_WIDTH'(obs_busy_cnt), '0);

      launch(16, 100, 1'b0);
      goto_rel(EXP_DONE_16 + 3);
      chk("l16_done_cycle", BEAT_WIDTH'(obs_done_rel), BEAT_WIDTH'(EXP_DONE_16));
      chk("l16_beats", BEAT_WIDTH'(obs_beats), BEAT_WIDTH'(8));
      chk("l16_lasts", BEAT_WIDTH'(obs_lasts), BEAT_WIDTH'(4));
      chk("l16_rd_last", BEAT_WIDTH'(obs_rd_last), BEAT_WIDTH'(107));

      launch(64, 'hFF0, 1'b0);
      goto_rel(EXP_DONE_64 + 3);
      chk("wrap_done_cycle", BEAT_WIDTH'(obs_done_rel), BEAT_WIDTH'(EXP_DONE_64));
      chk("wrap_beats", BEAT_WIDTH'(obs_beats), BEAT_WIDTH'(48));
      chk("wrap_rd_first", BEAT_WIDTH'(obs_rd_first), BEAT_WIDTH'('hFF0));
      chk("wrap_rd_last", BEAT_WIDTH'(obs_rd_last), BEAT_WIDTH'('h01F));
      chk("wrap_lasts", BEAT_WIDTH'(obs_lasts), BEAT_WIDTH'(6));

      // asynchronous reset in the middle of a stream
      launch(64, 0, 1'b0);
      goto_rel(20);
      rst_n  = 1'b0;
      m_kind = 0;
      #1;
      chk("midrst_vld", BEAT_WIDTH'(up_weight_vld), '0);
      chk("midrst_busy", BEAT_WIDTH'(busy), '0);
      chk("midrst_rd_en", BEAT_WIDTH'(mem_rd_en), '0);
      chk("midrst_dat", up_weight_dat, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      goto_rel(EXP_DONE_64 + 3);
      chk("midrst_no_done", BEAT_WIDTH'(obs_done_rel), BEAT_WIDTH'(-1));

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/butterfly_weight_streamer.md
Name: butterfly_weight_streamer

Overview:
- Transmit side of the butterfly_processor weight port (up_weight_dat / up_weight_vld).
- On start, reads every stage's twiddle/weight words from an on-chip weight SRAM (1-cycle read latency). Streams them stage by stage, beat by beat, as valid-qualified parallel words.
- Stream order matches what the processor ingests: stage 0 first, depth = length/(2*BU_PARALLELISM) beats per stage, log2(length) stages.

Parameters:
- DATA_WIDTH, 16, fp16 element width.
- BU_PARALLELISM, 4, butterfly units; one beat carries 4*BU_PARALLELISM elements.
- ADDR_WIDTH, 12, weight SRAM word-address width.
- MAX_LENGTH, 1024, largest legal transform length.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse; sampled only in IDLE.
- abort, input, 1, synchronous cancel.
- length, input, 16, transform length.
- base_addr, input, ADDR_WIDTH, SRAM word address of stage 0 beat 0.
- busy, output, 1, high while a stream is in progress.
- done, output, 1, 1-cycle pulse after the last beat.
- err, output, 1, 1-cycle pulse when a start carries an illegal length.
- mem_rd_en, output, 1, SRAM read enable.
- mem_rd_addr, output, ADDR_WIDTH, SRAM read address.
- mem_rd_dat, input, DATA_WIDTH*4*BU_PARALLELISM, SRAM data; valid the cycle after mem_rd_en.
- up_weight_vld, output, 1, weight beat valid.
- up_weight_dat, output, DATA_WIDTH*4*BU_PARALLELISM, weight beat; element k occupies bits [16k+15:16k].
- up_weight_stage, output, 4, stage index of the current beat.
- up_weight_stage_last, output, 1, marks the last beat of each stage.

Behaviour:
- Reset: every output 0; FSM in IDLE; counters 0.
- Length legality: length must be a power of two, 2*BU_PARALLELISM <= length <= MAX_LENGTH. Otherwise start pulses err in the next cycle and the FSM stays in IDLE with no SRAM access.
- Derived values: depth = length >> log2(2*BU_PARALLELISM); stages = log2(length). Both are latched at start.
- FSM states:
  - IDLE -> READ on a legal start (abort low).
  - READ: issues one read per cycle. mem_rd_addr = base_addr + beat_cnt, linear across stages. Goes to DRAIN after issuing beat total-1, where total = depth*stages.
  - DRAIN: waits until the last beat is emitted, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Pipeline, with start sampled in cycle 0:
  - mem_rd_en and mem_rd_addr are registered and first high in cycle 1.
  - mem_rd_dat is captured into up_weight_dat at the end of cycle 2.
  - up_weight_vld first high in cycle 3; fixed latency of 2 cycles from read to beat.
  - up_weight_stage and up_weight_stage_last travel in the same pipeline as the data.
- busy: high from cycle 1 through the done cycle inclusive.
- Address wrap-around: base_addr + beat_cnt wraps modulo 2^ADDR_WIDTH with no error.
- Start while busy: ignored.
- abort in READ or DRAIN:
  - next cycle mem_rd_en=0 and up_weight_vld=0, and any in-flight beat is discarded;
  - FSM returns to IDLE; no done; busy drops.
  - abort and start together in IDLE: abort wins.
- Asynchronous reset mid-stream: all outputs go to 0 immediately; no done.
- up_weight_dat holds its last value when up_weight_vld=0.

Optional Feature:
- BUTTERFLY_WEIGHT_PACE_EN defined:
  - A read is issued every other cycle, so up_weight_vld alternates 1,0 to match a consumer that accepts one beat per two cycles.
  - The last beat is followed immediately by DONE.
  - Stream length is 2*total-1 cycles.
- Undefined: one beat per cycle, back-to-back.

Decomposition:
- Package butterfly_weight_pkg holds:
  - FSM state enum (IDLE, READ, DRAIN, DONE);
  - beat width constant DATA_WIDTH*4*BU_PARALLELISM;
  - function for log2 of a power-of-two length;
  - function for the legality check.
- One sub-module, butterfly_len_decode: combinational length -> {legal, depth, stages}, reused by the processor's own control.

Test Plan:
- length=1024, BU_PARALLELISM=4, base_addr=0:
  - depth=128, stages=10, 1280 beats on addresses 0..1279;
  - up_weight_vld in cycles 3..1282 with no gaps; done in cycle 1283;
  - stage_last on beats 127, 255, ..., 1279; up_weight_stage steps 0..9;
  - data matches the SRAM model word for word.
- length=8: depth=1, stages=3, 3 beats, stage_last on every beat, stage 0,1,2; done in cycle 6.
- length=1000, then length=4096, then length=4: err pulses each time; mem_rd_en stays 0; busy stays 0.
- length=1024, abort during beat 100:
  - vld is 0 the next cycle;
  - no done; busy drops;
  - a following start with length=16 streams 2*4=8 beats correctly.
- base_addr=0xFF0 (ADDR_WIDTH=12), length=64: addresses run 0xFF0..0xFFF, then 0x000..; 48 beats total.
- With BUTTERFLY_WEIGHT_PACE_EN, length=1024: vld in odd cycles 3,5,...,2561; done in cycle 2562. A second start at beat 10 is ignored.
